// File: rtl/decode_stage.sv
// Registered RV32/RV64 base-ISA decode stage: field extraction, format classification,
// sign-extended immediate generation and illegal-opcode detection behind a valid/ready slot.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [6:0]       out_op,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [6:0]       out_funct7,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_rd_we,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decoded_count
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [2:0]      fmt_s;
  logic            illegal_s;
  logic [31:0]     imm32_s;
  logic [XLEN-1:0] imm_s;
  logic            rd_we_s;
  logic            accept_s;
  logic            drain_s;

  // Format classification from the opcode; compressed/short encodings are illegal
  always_comb begin
    fmt_s = FMT_ILL;
    if (in_instr[1:0] != 2'b11) begin
      fmt_s = FMT_ILL;
    end else begin
      case (in_instr[6:0])
        7'b0110011: fmt_s = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111,
        7'b1110011, 7'b0001111: fmt_s = FMT_I;
        7'b0100011: fmt_s = FMT_S;
        7'b1100011: fmt_s = FMT_B;
        7'b0110111, 7'b0010111: fmt_s = FMT_U;
        7'b1101111: fmt_s = FMT_J;
        default:    fmt_s = FMT_ILL;
      endcase
    end
    illegal_s = (fmt_s == FMT_ILL);
  end

  // 32-bit immediate per format, then sign-extended to XLEN
  always_comb begin
    case (fmt_s)
      FMT_I:   imm32_s = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   imm32_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm32_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   imm32_s = {in_instr[31:12], 12'b0};
      FMT_J:   imm32_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      default: imm32_s = 32'd0;
    endcase
    imm_s = XLEN'($signed(imm32_s));
  end

  // FENCE is I-format but never writes rd
  always_comb begin
    rd_we_s = 1'b0;
    if ((fmt_s == FMT_R || fmt_s == FMT_I || fmt_s == FMT_U || fmt_s == FMT_J) &&
        in_instr[11:7] != 5'd0 && in_instr[6:0] != 7'b0001111) begin
      rd_we_s = 1'b1;
    end else begin
      rd_we_s = 1'b0;
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept_s = in_valid && in_ready && !flush;
  assign drain_s  = out_valid && out_ready;

  // Single-entry output register; flush empties it but a drain in the same cycle still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_op        <= 7'd0;
      out_rd        <= 5'd0;
      out_funct3    <= 3'd0;
      out_rs1       <= 5'd0;
      out_rs2       <= 5'd0;
      out_funct7    <= 7'd0;
      out_fmt       <= 3'd0;
      out_imm       <= '0;
      out_rd_we     <= 1'b0;
      out_illegal   <= 1'b0;
      decoded_count <= '0;
    end else begin
      if (drain_s) begin
        decoded_count <= decoded_count + CNT_W'(1);
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept_s) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_op      <= in_instr[6:0];
        out_rd      <= in_instr[11:7];
        out_funct3  <= in_instr[14:12];
        out_rs1     <= in_instr[19:15];
        out_rs2     <= in_instr[24:20];
        out_funct7  <= in_instr[31:25];
        out_fmt     <= fmt_s;
        out_imm     <= imm_s;
        out_rd_we   <= rd_we_s;
        out_illegal <= illegal_s;
      end else if (drain_s) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: two instances (XLEN=32/CNT_W=16 and XLEN=64/CNT_W=2)
// share stimulus and are compared every cycle against a queue-based reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready, out_valid, out_rd_we, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_op, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_fmt;
  logic [15:0] decoded_count;

  logic        w_in_ready, w_out_valid, w_out_rd_we, w_out_illegal;
  logic [31:0] w_out_pc;
  logic [63:0] w_out_imm;
  logic [6:0]  w_out_op, w_out_funct7;
  logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;
  logic [2:0]  w_out_funct3, w_out_fmt;
  logic [1:0]  w_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op(out_op), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7), .out_fmt(out_fmt),
    .out_imm(out_imm), .out_rd_we(out_rd_we), .out_illegal(out_illegal),
    .decoded_count(decoded_count));

  decode_stage #(.XLEN(64), .PC_W(32), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_pc(w_out_pc), .out_op(w_out_op), .out_rd(w_out_rd), .out_funct3(w_out_funct3),
    .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_funct7(w_out_funct7), .out_fmt(w_out_fmt),
    .out_imm(w_out_imm), .out_rd_we(w_out_rd_we), .out_illegal(w_out_illegal),
    .decoded_count(w_count));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode computed arithmetically from a sign-extended copy of the word
  function automatic void mdec(input logic [31:0] i, output int fmt, output longint imm,
                               output bit we);
    longint s;
    logic [6:0] op;
    s  = longint'(int'(i));
    op = i[6:0];
    if (i[1:0] != 2'b11) fmt = 7;
    else if (op == 7'h33) fmt = 0;
    else if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73 || op == 7'h0F) fmt = 1;
    else if (op == 7'h23) fmt = 2;
    else if (op == 7'h63) fmt = 3;
    else if (op == 7'h37 || op == 7'h17) fmt = 4;
    else if (op == 7'h6F) fmt = 5;
    else fmt = 7;
    case (fmt)
      1: imm = s >>> 20;
      2: imm = ((s >>> 25) << 5) | longint'(i[11:7]);
      3: imm = ((s >>> 31) << 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5)
               | (longint'(i[11:8]) << 1);
      4: imm = s & 64'hFFFF_FFFF_FFFF_F000;
      5: imm = ((s >>> 31) << 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11)
               | (longint'(i[30:21]) << 1);
      default: imm = 0;
    endcase
    we = (fmt == 0 || fmt == 1 || fmt == 4 || fmt == 5) && i[11:7] != 5'd0 && op != 7'h0F;
  endfunction

  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        q[$];
  int unsigned m_cnt;

  // Reference model: a one-deep queue plus a handshake tally
  always @(posedge clk or negedge rst_n) begin
    bit rdy;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
    end else begin
      rdy = (q.size() == 0) || out_ready;
      if (q.size() != 0 && out_ready) begin
        void'(q.pop_front());
        m_cnt++;
      end
      if (flush) q.delete();
      else if (in_valid && rdy) q.push_back('{instr: in_instr, pc: in_pc});
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    bit ev;
    int f;
    longint im;
    bit we;
    logic [31:0] mi;
    ev = (q.size() != 0);
    chk("valid", 64'(out_valid), 64'(ev));
    chk("valid64", 64'(w_out_valid), 64'(ev));
    chk("in_ready", 64'(in_ready), 64'(!ev || out_ready));
    chk("in_ready64", 64'(w_in_ready), 64'(!ev || out_ready));
    chk("count", 64'(decoded_count), 64'(m_cnt % 65536));
    chk("count64", 64'(w_count), 64'(m_cnt % 4));
    if (ev) begin
      mi = q[0].instr;
      mdec(mi, f, im, we);
      chk("pc", 64'(out_pc), 64'(q[0].pc));
      chk("op", 64'(out_op), 64'(mi[6:0]));
      chk("rd", 64'(out_rd), 64'(mi[11:7]));
      chk("funct3", 64'(out_funct3), 64'(mi[14:12]));
      chk("rs1", 64'(out_rs1), 64'(mi[19:15]));
      chk("rs2", 64'(out_rs2), 64'(mi[24:20]));
      chk("funct7", 64'(out_funct7), 64'(mi[31:25]));
      chk("fmt", 64'(out_fmt), 64'(f));
      chk("fmt64", 64'(w_out_fmt), 64'(f));
      chk("imm", 64'(out_imm), im & 64'hFFFF_FFFF);
      chk("imm64", w_out_imm, im);
      chk("rd_we", 64'(out_rd_we), 64'(we));
      chk("rd_we64", 64'(w_out_rd_we), 64'(we));
      chk("illegal", 64'(out_illegal), 64'(f == 7));
      chk("pc64", 64'(w_out_pc), 64'(q[0].pc));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    cyc();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0]  ops [10];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h6F};
    w = $urandom;
    if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    out_ready = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(decoded_count), 64'd0);
    chk("rst_fmt", 64'(out_fmt), 64'd0);
    chk("rst_imm", 64'(w_out_imm), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_flags", 64'({out_rd_we, out_illegal}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    cyc();
    out_ready = 1'b1;

    issue(32'hFFF0_0093, 32'h100);
    chk("addi_fmt", 64'(out_fmt), 64'd1);
    chk("addi_rd", 64'(out_rd), 64'd1);
    chk("addi_rs1", 64'(out_rs1), 64'd0);
    chk("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
    chk("addi_imm64", w_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_we", 64'(out_rd_we), 64'd1);
    chk("addi_pc", 64'(out_pc), 64'h100);
    cyc();
    chk("addi_count", 64'(decoded_count), 64'd1);

    issue(32'h0020_A423, 32'h104);
    chk("sw_fmt", 64'(out_fmt), 64'd2);
    chk("sw_regs", 64'({out_rs1, out_rs2, out_funct3}), 64'({5'd1, 5'd2, 3'd2}));
    chk("sw_imm", 64'(out_imm), 64'd8);
    chk("sw_we", 64'(out_rd_we), 64'd0);
    cyc();

    issue(32'hFE00_0EE3, 32'h108);
    chk("beq_fmt", 64'(out_fmt), 64'd3);
    chk("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
    cyc();

    issue(32'h1234_52B7, 32'h10C);
    chk("lui_fmt", 64'(out_fmt), 64'd4);
    chk("lui_imm", 64'(out_imm), 64'h1234_5000);
    chk("lui_we", 64'(out_rd_we), 64'd1);
    cyc();

    issue(32'h0000_0000, 32'h110);
    chk("ill_flag", 64'(out_illegal), 64'd1);
    chk("ill_fmt", 64'(out_fmt), 64'd7);
    chk("ill_imm", 64'(out_imm), 64'd0);
    chk("ill_we", 64'(out_rd_we), 64'd0);
    cyc();

    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0050_0113; in_pc = 32'h200;
    cyc();
    in_instr = 32'h0020_81B3; in_pc = 32'h204;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("bp_pc", 64'(out_pc), 64'h200);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_count", 64'(decoded_count), 64'd5);
    end
    out_ready = 1'b1;
    cyc();
    chk("stream_pc1", 64'(out_pc), 64'h204);
    chk("stream_count1", 64'(decoded_count), 64'd6);
    in_instr = 32'h0000_006F; in_pc = 32'h208;
    cyc();
    chk("stream_pc2", 64'(out_pc), 64'h208);
    chk("stream_valid2", 64'(out_valid), 64'd1);
    in_valid = 1'b0; out_ready = 1'b0;
    cyc();
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 32'h20C;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_count", 64'(decoded_count), 64'd7);

    issue(32'h0010_0093, 32'h300);
    chk("mr_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid0", 64'(out_valid), 64'd0);
    chk("mr_count", 64'(decoded_count), 64'd0);
    chk("mr_count64", 64'(w_count), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) issue(rnd_instr(), 32'h400 + 32'(4 * k));
    cyc();
    chk("wrap_count", 64'(decoded_count), 64'd5);
    chk("wrap_count64", 64'(w_count), 64'd1);

    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      in_instr  = rnd_instr();
      in_pc     = $urandom;
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
